// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e    : fetch FSM states (request, wait, output, drop)
//   NOP_INSTR        : instruction presented whenever no real fetch is valid
//   DEFAULT_RESET_PC : default PC loaded on reset
//   align_word()     : clears the byte-offset bits of an address
package fetch_pkg;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StOut,
        StDrop
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus.
//   imem_req    : request valid (fetch -> memory)
//   imem_addr   : request address (fetch -> memory)
//   imem_ready  : memory accepts the request this cycle (memory -> fetch)
//   imem_rvalid : response data valid (memory -> fetch)
//   imem_rdata  : response instruction word (memory -> fetch)
// master is the fetch side, slave is the memory side.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register with +4 incrementer and redirect mux.
//   clk, rst      : clock, asynchronous active-high reset (loads RESET_PC)
//   redirect_i    : load target_i (word-aligned); wins over advance_i
//   target_i      : redirect address
//   advance_i     : step PC by 4 (wraps modulo 2^32)
//   pc_o          : current PC
//   pc_plus4_o    : current PC + 4
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        advance_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    assign pc_plus4_o = pc_q + 32'd4;
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = align_word(target_i);
        end else if (advance_i) begin
            pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one memory request at a time, buffers the
// returned word and presents it to decode until consumed.
//   clk, rst        : clock, asynchronous active-high reset
//   stallF          : 1 = decode does not consume the presented instruction
//   PCSrcE          : redirect from execute (taken branch / jump)
//   PCTargetE       : redirect target
//   imem            : instruction-memory bus (master side)
//   instrF/PCF      : presented instruction and its address
//   PCPlus4F        : PCF + 4
//   validF          : instrF/PCF hold a real fetched instruction
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stallF,
    input  logic           PCSrcE,
    input  logic [31:0]    PCTargetE,
    fetch_if.master        imem,
    output logic [31:0]    instrF,
    output logic [31:0]    PCF,
    output logic [31:0]    PCPlus4F,
    output logic           validF
);

    fetch_state_e state_q;
    logic [31:0]  buf_q;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         accept;
    logic         advance;

    // imem_req is high whenever we are in StReq out of reset, so ready alone
    // decides acceptance there.
    assign accept  = (state_q == StReq) && imem.imem_ready;
    assign advance = (state_q == StOut) && !stallF;

    fetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk        (clk),
        .rst        (rst),
        .redirect_i (PCSrcE),
        .target_i   (PCTargetE),
        .advance_i  (advance),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StReq;
            buf_q   <= NOP_INSTR;
        end else begin
            unique case (state_q)
                StReq: begin
                    // A request accepted alongside a redirect fetched the old
                    // address; its response must be swallowed.
                    if (accept) begin
                        state_q <= PCSrcE ? StDrop : StWait;
                    end
                end
                StWait: begin
                    if (PCSrcE) begin
                        state_q <= imem.imem_rvalid ? StReq : StDrop;
                    end else if (imem.imem_rvalid) begin
                        buf_q   <= imem.imem_rdata;
                        state_q <= StOut;
                    end
                end
                StOut: begin
                    if (PCSrcE) begin
                        buf_q   <= NOP_INSTR;
                        state_q <= StReq;
                    end else if (!stallF) begin
                        state_q <= StReq;
                    end
                end
                StDrop: begin
                    if (imem.imem_rvalid) begin
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

    // Decoded from state only, so imem_req never sees rvalid/rdata.
    assign imem.imem_req  = (state_q == StReq) && !rst;
    assign imem.imem_addr = pc;

    assign validF   = (state_q == StOut);
    assign instrF   = validF ? buf_q : NOP_INSTR;
    assign PCF      = pc;
    assign PCPlus4F = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallF = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic [31:0] instrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        validF;

    int nvec = 0;
    int nerr = 0;
    exp_t sb[$];

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stallF    (stallF),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (bus),
        .instrF    (instrF),
        .PCF       (PCF),
        .PCPlus4F  (PCPlus4F),
        .validF    (validF)
    );

    always #5 clk = ~clk;

    // Memory image: distinct word per address, with a fixed word at 0x8.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h0050_0093;
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    // Memory responder: accepts are noted at the edge, rvalid is a single
    // pulse mem_lat cycles after the accepting edge.
    int          mem_lat = 1;
    int unsigned acc_num = 0;
    logic [31:0] acc_addr = 32'h0;
    int unsigned seen_num = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;

    always @(posedge clk) begin
        if (!rst && bus.imem_req && bus.imem_ready) begin
            acc_num  <= acc_num + 1;
            acc_addr <= bus.imem_addr;
        end
    end

    always @(negedge clk) begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        if (acc_num != seen_num) begin
            seen_num  = acc_num;
            pend      = 1'b1;
            pend_addr = acc_addr;
            pend_cnt  = mem_lat;
        end
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt <= 0) begin
                pend            = 1'b0;
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend_addr);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit got, output int n);
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            cyc();
            n++;
            if (validF === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        repeat (2) cyc();
        nvec++; if (validF !== 1'b0) begin nerr++; $display("FAIL rst_validF: got %b want 0", validF); end
        nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        nvec++; if (PCF !== RST_PC) begin nerr++; $display("FAIL rst_pcf: got %h want %h", PCF, RST_PC); end
        nvec++; if (instrF !== NOP_INSTR) begin nerr++; $display("FAIL rst_instr: got %h want %h", instrF, NOP_INSTR); end
        nvec++; if (PCPlus4F !== RST_PC + 32'd4) begin nerr++; $display("FAIL rst_pc4: got %h want %h", PCPlus4F, RST_PC + 32'd4); end
        rst = 1'b0;
        #1;
        nvec++; if (bus.imem_req !== 1'b1) begin nerr++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        nvec++; if (bus.imem_addr !== RST_PC) begin nerr++; $display("FAIL first_addr: got %h want %h", bus.imem_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        exp_t e;
        bit   got;
        int   n;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{pc: RST_PC + 32'(4 * k), instr: mem_word(RST_PC + 32'(4 * k))});
        end
        mem_lat = 1;
        bus.imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(10, got, n);
            nvec++;
            if (!got) begin
                nerr++; $display("FAIL seq_valid%0d: validF=0 after %0d cycles, want 1", k, n);
                return;
            end
            if (k == 0) begin
                nvec++; if (n != 2) begin nerr++; $display("FAIL seq_latency: got %0d cycles want 2", n); end
            end
            e = sb.pop_front();
            nvec++; if (PCF !== e.pc) begin nerr++; $display("FAIL seq_pcf%0d: got %h want %h", k, PCF, e.pc); end
            nvec++; if (instrF !== e.instr) begin nerr++; $display("FAIL seq_instr%0d: got %h want %h", k, instrF, e.instr); end
            nvec++; if (PCPlus4F !== e.pc + 32'd4) begin nerr++; $display("FAIL seq_pc4_%0d: got %h want %h", k, PCPlus4F, e.pc + 32'd4); end
            if (k == 2) stallF = 1'b1;
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            cyc();
            nvec++; if (validF !== 1'b1) begin nerr++; $display("FAIL stall_valid%0d: got %b want 1", i, validF); end
            nvec++; if (PCF !== 32'h8) begin nerr++; $display("FAIL stall_pcf%0d: got %h want 00000008", i, PCF); end
            nvec++; if (instrF !== 32'h0050_0093) begin nerr++; $display("FAIL stall_instr%0d: got %h want 00500093", i, instrF); end
            nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL stall_req%0d: got %b want 0", i, bus.imem_req); end
        end
        stallF = 1'b0;
        cyc();
        nvec++; if (bus.imem_req !== 1'b1) begin nerr++; $display("FAIL unstall_req: got %b want 1", bus.imem_req); end
        nvec++; if (bus.imem_addr !== 32'hC) begin nerr++; $display("FAIL unstall_addr: got %h want 0000000c", bus.imem_addr); end
        bus.imem_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3;
        bus.imem_ready = 1'b1;
        cyc();
        nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rw_wait_req: got %b want 0", bus.imem_req); end
        bus.imem_ready = 1'b0;
        PCSrcE = 1'b1;
        PCTargetE = 32'h100;
        cyc();
        PCSrcE = 1'b0;
        nvec++; if (PCF !== 32'h100) begin nerr++; $display("FAIL rw_pcf: got %h want 00000100", PCF); end
        for (int i = 0; i < 2; i++) begin
            nvec++; if (validF !== 1'b0) begin nerr++; $display("FAIL rw_valid%0d: got %b want 0", i, validF); end
            nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rw_drop_req%0d: got %b want 0", i, bus.imem_req); end
            cyc();
        end
        nvec++; if (validF !== 1'b0) begin nerr++; $display("FAIL rw_stale_valid: got %b want 0", validF); end
        nvec++; if (bus.imem_req !== 1'b1) begin nerr++; $display("FAIL rw_req: got %b want 1", bus.imem_req); end
        nvec++; if (bus.imem_addr !== 32'h100) begin nerr++; $display("FAIL rw_addr: got %h want 00000100", bus.imem_addr); end
    endtask

    task automatic test_redirect_req();
        exp_t e;
        bit   got;
        int   n;
        mem_lat = 1;
        bus.imem_ready = 1'b1;
        PCSrcE = 1'b1;
        PCTargetE = 32'h203;
        cyc();
        PCSrcE = 1'b0;
        bus.imem_ready = 1'b0;
        nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rr_drop_req: got %b want 0", bus.imem_req); end
        nvec++; if (PCF !== 32'h200) begin nerr++; $display("FAIL rr_pcf: got %h want 00000200", PCF); end
        cyc();
        nvec++; if (validF !== 1'b0) begin nerr++; $display("FAIL rr_valid: got %b want 0", validF); end
        nvec++; if (bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1) begin
            nerr++; $display("FAIL rr_req: got req=%b addr=%h want req=1 addr=00000200", bus.imem_req, bus.imem_addr);
        end
        sb.push_back('{pc: 32'h200, instr: mem_word(32'h200)});
        bus.imem_ready = 1'b1;
        wait_valid(10, got, n);
        nvec++;
        if (!got) begin
            nerr++; $display("FAIL rr_fetch: validF=0 after %0d cycles, want 1", n);
            return;
        end
        stallF = 1'b1;
        bus.imem_ready = 1'b0;
        e = sb.pop_front();
        nvec++; if (PCF !== e.pc) begin nerr++; $display("FAIL rr_fetch_pcf: got %h want %h", PCF, e.pc); end
        nvec++; if (instrF !== e.instr) begin nerr++; $display("FAIL rr_fetch_instr: got %h want %h", instrF, e.instr); end
    endtask

    // Redirect while stalled in OUT: redirect wins, buffer discarded.
    task automatic test_redirect_out();
        cyc();
        nvec++; if (validF !== 1'b1 || PCF !== 32'h200) begin
            nerr++; $display("FAIL ro_hold: got valid=%b pcf=%h want valid=1 pcf=00000200", validF, PCF);
        end
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFE;
        cyc();
        PCSrcE = 1'b0;
        stallF = 1'b0;
        nvec++; if (validF !== 1'b0) begin nerr++; $display("FAIL ro_valid: got %b want 0", validF); end
        nvec++; if (instrF !== NOP_INSTR) begin nerr++; $display("FAIL ro_instr: got %h want %h", instrF, NOP_INSTR); end
        nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
            nerr++; $display("FAIL ro_req: got req=%b addr=%h want req=1 addr=fffffffc", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        bit   got;
        int   n;
        sb.push_back('{pc: 32'hFFFF_FFFC, instr: mem_word(32'hFFFF_FFFC)});
        mem_lat = 1;
        bus.imem_ready = 1'b1;
        wait_valid(10, got, n);
        nvec++;
        if (!got) begin
            nerr++; $display("FAIL wrap_fetch: validF=0 after %0d cycles, want 1", n);
            return;
        end
        bus.imem_ready = 1'b0;
        e = sb.pop_front();
        nvec++; if (PCF !== e.pc) begin nerr++; $display("FAIL wrap_pcf: got %h want %h", PCF, e.pc); end
        nvec++; if (instrF !== e.instr) begin nerr++; $display("FAIL wrap_instr: got %h want %h", instrF, e.instr); end
        nvec++; if (PCPlus4F !== 32'h0) begin nerr++; $display("FAIL wrap_pc4: got %h want 00000000", PCPlus4F); end
        cyc();
        nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            nerr++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   got;
        int   n;
        PCSrcE = 1'b1;
        PCTargetE = 32'h40;
        cyc();
        PCSrcE = 1'b0;
        nvec++; if (bus.imem_addr !== 32'h40) begin nerr++; $display("FAIL rm_park_addr: got %h want 00000040", bus.imem_addr); end
        mem_lat = 3;
        bus.imem_ready = 1'b1;
        cyc();
        bus.imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL rm_rst_req: got %b want 0", bus.imem_req); end
        nvec++; if (PCF !== RST_PC) begin nerr++; $display("FAIL rm_rst_pcf: got %h want %h", PCF, RST_PC); end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            nvec++; if (validF !== 1'b0) begin nerr++; $display("FAIL rm_late_valid%0d: got %b want 0", i, validF); end
            nvec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
                nerr++; $display("FAIL rm_req%0d: got req=%b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, RST_PC);
            end
        end
        sb.push_back('{pc: RST_PC, instr: mem_word(RST_PC)});
        mem_lat = 1;
        bus.imem_ready = 1'b1;
        wait_valid(10, got, n);
        nvec++;
        if (!got) begin
            nerr++; $display("FAIL rm_fetch: validF=0 after %0d cycles, want 1", n);
            return;
        end
        bus.imem_ready = 1'b0;
        e = sb.pop_front();
        nvec++; if (PCF !== e.pc) begin nerr++; $display("FAIL rm_fetch_pcf: got %h want %h", PCF, e.pc); end
        nvec++; if (instrF !== e.instr) begin nerr++; $display("FAIL rm_fetch_instr: got %h want %h", instrF, e.instr); end
    endtask

    initial begin
        bus.imem_ready = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_out();
        test_wrap();
        test_reset_mid();
        nvec++;
        if (sb.size() != 0) begin
            nerr++; $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-004 The block SHALL have port stallF, input, 1, hazard-unit hold; 1 = downstream does not consume the presented instruction.
REQ-005 The block SHALL have port PCSrcE, input, 1, taken branch/jump redirect from execute.
REQ-006 The block SHALL have port PCTargetE, input, 32, redirect target address.
REQ-007 The block SHALL have port imem_req, output, 1, instruction-memory request valid.
REQ-008 The block SHALL have port imem_addr, output, 32, request address.
REQ-009 The block SHALL have port imem_ready, input, 1, memory accepts the request this cycle (req & ready = accepted).
REQ-010 The block SHALL have port imem_rvalid, input, 1, response data valid.
REQ-011 The block SHALL have port imem_rdata, input, 32, response instruction word.
REQ-012 The block SHALL have ports instrF/PCF/PCPlus4F, output, 32 each, fetched instruction, its address, and address+4, feeding the decode pipeline register.
REQ-013 The block SHALL have port validF, output, 1, instrF/PCF are a real fetched instruction.

Function
REQ-014 The block SHALL hold at most one outstanding memory request.
REQ-015 FSM states SHALL be REQ, WAIT, OUT, DROP.
REQ-016 REQ: imem_req=1, imem_addr=PC; on accept -> WAIT, else stay.
REQ-017 WAIT: imem_req=0; on imem_rvalid capture imem_rdata into the instruction buffer -> OUT.
REQ-018 OUT: validF=1, instrF=buffer, PCF=PC; if stallF=0, PC<=PC+4 -> REQ; if stallF=1 hold all outputs and stay.
REQ-019 DROP: imem_req=0; on imem_rvalid discard data -> REQ.
REQ-020 PCSrcE=1 SHALL take priority over stallF and all FSM transitions: PC<=PCTargetE with bits [1:0] forced to 0.
REQ-021 Redirect in REQ: if accepted the same cycle -> DROP, else -> REQ (the new address is driven the next cycle).
REQ-022 Redirect in WAIT: if imem_rvalid the same cycle -> REQ with data discarded, else -> DROP.
REQ-023 Redirect in OUT: discard the buffer and go to REQ.
REQ-024 Redirect in DROP: update PC only; stay DROP until rvalid.
REQ-025 validF SHALL be 0 in every state except OUT; in those states instrF=32'h0000_0013 (NOP) and PCF=PC.
REQ-026 PCPlus4F SHALL equal PCF+4 modulo 2^32; PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-027 imem_req SHALL never depend combinationally on imem_rvalid or imem_rdata.
REQ-028 Minimum latency SHALL be: request cycle, then rvalid at earliest 1 cycle after accept, then validF the cycle after rvalid.

Reset
REQ-029 On rst=1: PC=RESET_PC, state=REQ, buffer=NOP, validF=0, imem_req=0 while rst is asserted.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; a late rvalid arriving in REQ SHALL be ignored.
REQ-031 The first request after reset deassertion SHALL be issued on the first clock edge with imem_addr=RESET_PC.

Structure
REQ-032 Package fetch_pkg SHALL hold the FSM state enum, the NOP_INSTR constant (32'h0000_0013), and the default reset PC constant.
REQ-033 The PC register, +4 adder, and redirect mux SHALL be one sub-module, fetch_pc_gen; the FSM and buffer stay in fetch_unit.

Verification
REQ-034 Reset, ready=1, rvalid 1 cycle after accept, stallF=0: sequential fetch 0x0,0x4,0x8 appears on PCF with validF pulses and matching instrF.
REQ-035 stallF=1 for 3 cycles in OUT with instr 0x00500093 at PCF=0x8: outputs held constant, no imem_req; release -> request to 0xC.
REQ-036 Redirect to 0x100 in WAIT, rvalid 2 cycles later: stale data discarded, validF stays 0, next request addr=0x100.
REQ-037 Redirect to 0x203 coincident with accept in REQ: DROP entered, next request addr=0x200.
REQ-038 PC=0xFFFF_FFFC consumed: PCPlus4F=0x0, next request addr=0x0.
REQ-039 rst asserted while in WAIT, then rvalid arrives after release: data ignored, first validF instruction has PCF=RESET_PC.
